// File: rtl/xor_frame_accum_if.sv
// Stream-in / result-out bundle for xor_frame_accum (word stream plus held result).
// Pure wiring, no latency.
// in_valid/in_ready for words, out_valid/out_ready for the result; XOR_FRAME_CHECK_EN adds exp_xor/out_err.
interface xor_frame_accum_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  // word stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  // held frame result
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xor;
  logic             out_parity;
  logic [CW-1:0]    out_count;
  logic             out_overflow;

  // status
  logic             busy;

`ifdef XOR_FRAME_CHECK_EN
  logic [WIDTH-1:0] exp_xor;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready, exp_xor,
    input  in_ready, out_valid, out_xor, out_parity, out_count, out_overflow, busy, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready, exp_xor,
    output in_ready, out_valid, out_xor, out_parity, out_count, out_overflow, busy, out_err
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_xor, out_parity, out_count, out_overflow, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_xor, out_parity, out_count, out_overflow, busy
  );
`endif

endinterface

// File: rtl/xor_frame_accum.sv
// Folds a frame of words into a running XOR and holds checksum/parity/count (+ out_err when XOR_FRAME_CHECK_EN).
// Latency: result registered on the edge accepting the in_last word, out_valid visible next cycle.
// Backpressure: in_ready drops while a result is held; a new word is taken only after the output handshake.
module xor_frame_accum #(
  parameter int WIDTH      = 8,
  parameter int MAX_WORDS  = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst_n,
  xor_frame_accum_if.slave bus
);

  localparam int            CW      = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic          PAR_INV = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // running frame state
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ovf, ovf_nxt;

  // output holding register
  logic [WIDTH-1:0] res_xor, res_xor_nxt;
  logic [CW-1:0]    res_cnt, res_cnt_nxt;
  logic             res_ovf, res_ovf_nxt;
`ifdef XOR_FRAME_CHECK_EN
  logic             res_err, res_err_nxt;
`endif

  logic             ready;
  logic             hold;
  logic             accept;
  logic             out_fire;
  logic             cnt_full;
  logic [WIDTH-1:0] fold;
  logic [CW-1:0]    cnt_inc;
  logic             ovf_inc;

  // ready depends only on state, so the input side never waits on out_ready combinationally
  assign ready    = (state != HOLD);
  assign hold     = (state == HOLD);
  assign accept   = bus.in_valid && ready;
  assign out_fire = hold && bus.out_ready;

  // fold/count helpers for a word arriving in ACCUM; the counter sticks at MAX_WORDS
  // and any word arriving while it is full marks the frame as overflowed
  assign cnt_full = (cnt == CNT_MAX);
  assign fold     = acc ^ bus.in_data;
  assign cnt_inc  = cnt_full ? cnt : (cnt + CNT_ONE);
  assign ovf_inc  = ovf | cnt_full;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and datapath next values
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    res_xor_nxt = res_xor;
    res_cnt_nxt = res_cnt;
    res_ovf_nxt = res_ovf;
`ifdef XOR_FRAME_CHECK_EN
    res_err_nxt = res_err;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_last) begin
            // single-word frame goes straight into the holding register
            res_xor_nxt = bus.in_data;
            res_cnt_nxt = CNT_ONE;
            res_ovf_nxt = 1'b0;
`ifdef XOR_FRAME_CHECK_EN
            res_err_nxt = (bus.in_data != bus.exp_xor);
`endif
            acc_nxt     = '0;
            cnt_nxt     = '0;
            ovf_nxt     = 1'b0;
            state_nxt   = HOLD;
          end else begin
            acc_nxt   = bus.in_data;
            cnt_nxt   = CNT_ONE;
            ovf_nxt   = 1'b0;
            state_nxt = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          if (bus.in_last) begin
            // final word: capture the completed frame on this same edge
            res_xor_nxt = fold;
            res_cnt_nxt = cnt_inc;
            res_ovf_nxt = ovf_inc;
`ifdef XOR_FRAME_CHECK_EN
            res_err_nxt = (fold != bus.exp_xor);
`endif
            acc_nxt     = '0;
            cnt_nxt     = '0;
            ovf_nxt     = 1'b0;
            state_nxt   = HOLD;
          end else begin
            acc_nxt = fold;
            cnt_nxt = cnt_inc;
            ovf_nxt = ovf_inc;
          end
        end
      end

      HOLD: begin
        // result data stays in place after the handshake; only valid drops
        if (out_fire) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // accumulator, counter and overflow flag for the frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  // output holding register, loaded only when a frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_xor <= '0;
      res_cnt <= '0;
      res_ovf <= 1'b0;
    end else begin
      res_xor <= res_xor_nxt;
      res_cnt <= res_cnt_nxt;
      res_ovf <= res_ovf_nxt;
    end
  end

`ifdef XOR_FRAME_CHECK_EN
  // compare flag held alongside the checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err <= 1'b0;
    end else begin
      res_err <= res_err_nxt;
    end
  end

  assign bus.out_err = res_err;
`endif

  assign bus.in_ready     = ready;
  assign bus.out_valid    = hold;
  assign bus.out_xor      = res_xor;
  // parity follows the held checksum, never the live accumulator
  assign bus.out_parity   = (^res_xor) ^ PAR_INV;
  assign bus.out_count    = res_cnt;
  assign bus.out_overflow = res_ovf;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_xor_frame_accum.sv
// Bench for xor_frame_accum: two instances (MAX_WORDS=4 even parity, MAX_WORDS=1 odd parity) on one stimulus.
// A frame-level model (word count and XOR of the frame) is checked against both DUTs every cycle.
// Directed frames with literal expectations pin the model.
module tb_xor_frame_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [7:0] exp_in = 8'h00;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int vcnt;

  always #5 clk = ~clk;

  xor_frame_accum_if #(.WIDTH(8), .MAX_WORDS(4)) bus_e ();
  xor_frame_accum_if #(.WIDTH(8), .MAX_WORDS(1)) bus_o ();

  assign bus_e.in_valid  = in_valid;
  assign bus_e.in_data   = in_data;
  assign bus_e.in_last   = in_last;
  assign bus_e.out_ready = out_ready;
  assign bus_o.in_valid  = in_valid;
  assign bus_o.in_data   = in_data;
  assign bus_o.in_last   = in_last;
  assign bus_o.out_ready = out_ready;
`ifdef XOR_FRAME_CHECK_EN
  assign bus_e.exp_xor   = exp_in;
  assign bus_o.exp_xor   = exp_in;
`endif

  xor_frame_accum #(.WIDTH(8), .MAX_WORDS(4), .PARITY_ODD(0)) u_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e)
  );

  xor_frame_accum #(.WIDTH(8), .MAX_WORDS(1), .PARITY_ODD(1)) u_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o)
  );

  // ---------------- frame-level model ----------------
  int         m_n;     // words seen so far in the open frame
  logic [7:0] m_x;     // XOR of those words
  bit         m_held;  // a completed result awaits its handshake
  logic [7:0] m_rx;    // last completed frame checksum
  int         m_rn;    // last completed frame true length (unsaturated)
  bit         m_rerr;  // last completed frame checksum != expected

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_x <= 8'h00; m_held <= 1'b0;
      m_rx <= 8'h00; m_rn <= 0; m_rerr <= 1'b0;
    end else if (m_held) begin
      if (out_ready) m_held <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        m_rx   <= m_x ^ in_data;
        m_rn   <= m_n + 1;
        m_rerr <= ((m_x ^ in_data) != exp_in);
        m_held <= 1'b1;
        m_n    <= 0;
        m_x    <= 8'h00;
      end else begin
        m_x <= m_x ^ in_data;
        m_n <= m_n + 1;
      end
    end
  end

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("e.in_ready",     32'(bus_e.in_ready),     32'(!m_held));
      check("e.out_valid",    32'(bus_e.out_valid),    32'(m_held));
      check("e.busy",         32'(bus_e.busy),         32'(m_held || (m_n > 0)));
      check("e.out_xor",      32'(bus_e.out_xor),      32'(m_rx));
      check("e.out_parity",   32'(bus_e.out_parity),   32'(^m_rx));
      check("e.out_count",    32'(bus_e.out_count),    32'(sat(m_rn, 4)));
      check("e.out_overflow", 32'(bus_e.out_overflow), 32'(m_rn > 4));
      check("o.in_ready",     32'(bus_o.in_ready),     32'(!m_held));
      check("o.out_valid",    32'(bus_o.out_valid),    32'(m_held));
      check("o.busy",         32'(bus_o.busy),         32'(m_held || (m_n > 0)));
      check("o.out_xor",      32'(bus_o.out_xor),      32'(m_rx));
      check("o.out_parity",   32'(bus_o.out_parity),   32'(~^m_rx));
      check("o.out_count",    32'(bus_o.out_count),    32'(sat(m_rn, 1)));
      check("o.out_overflow", 32'(bus_o.out_overflow), 32'(m_rn > 1));
`ifdef XOR_FRAME_CHECK_EN
      check("e.out_err",      32'(bus_e.out_err),      32'(m_held ? m_rerr : m_rerr));
      check("o.out_err",      32'(bus_o.out_err),      32'(m_rerr));
`endif
    end
  end

  // one word for one cycle; returns 1 time unit after the edge that sampled it
  task automatic push(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset asserted between edges, outputs must clear without a clock
    #2 rst_n = 1'b0;
    #1;
    check("rst.e.in_ready",   32'(bus_e.in_ready),   32'd1);
    check("rst.e.busy",       32'(bus_e.busy),       32'd0);
    check("rst.e.out_valid",  32'(bus_e.out_valid),  32'd0);
    check("rst.e.out_parity", 32'(bus_e.out_parity), 32'd0);
    check("rst.o.out_parity", 32'(bus_o.out_parity), 32'd1);
    check("rst.e.out_count",  32'(bus_e.out_count),  32'd0);
    chk_en = 1'b1;
    idle_cycles(2);
    #2 rst_n = 1'b1;
    idle_cycles(1);

    // 3-word frame: A5 ^ 3C ^ 0F = 96
    exp_in = 8'h96;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    push(8'h0F, 1'b1);
    check("f3.e.out_valid",    32'(bus_e.out_valid),    32'd1);
    check("f3.e.out_xor",      32'(bus_e.out_xor),      32'h96);
    check("f3.e.out_parity",   32'(bus_e.out_parity),   32'd0);
    check("f3.e.out_count",    32'(bus_e.out_count),    32'd3);
    check("f3.e.out_overflow", 32'(bus_e.out_overflow), 32'd0);
    check("f3.o.out_count",    32'(bus_o.out_count),    32'd1);
    check("f3.o.out_overflow", 32'(bus_o.out_overflow), 32'd1);
    check("f3.o.out_parity",   32'(bus_o.out_parity),   32'd1);
`ifdef XOR_FRAME_CHECK_EN
    check("f3.e.out_err",      32'(bus_e.out_err),      32'd0);
`endif
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      vcnt += int'(bus_e.out_valid);
      @(posedge clk); #1;
    end
    check("f3.valid_cycles", 32'(vcnt), 32'd1);
    check("f3.e.xor_kept",   32'(bus_e.out_xor), 32'h96);

    // same frame with a wrong expected checksum
    exp_in = 8'h97;
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    push(8'h0F, 1'b1);
`ifdef XOR_FRAME_CHECK_EN
    check("f3b.e.out_err", 32'(bus_e.out_err), 32'd1);
`endif
    check("f3b.e.out_xor", 32'(bus_e.out_xor), 32'h96);
    idle_cycles(2);

    // single-word frame held under backpressure; a pending word must wait
    exp_in = 8'h01;
    out_ready = 1'b0;
    push(8'h01, 1'b1);
    check("f1.e.out_xor",    32'(bus_e.out_xor),    32'h01);
    check("f1.e.out_parity", 32'(bus_e.out_parity), 32'd1);
    check("f1.o.out_parity", 32'(bus_o.out_parity), 32'd0);
    check("f1.o.out_count",  32'(bus_o.out_count),  32'd1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    exp_in   = 8'h55;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      check("f1.e.in_ready_low", 32'(bus_e.in_ready), 32'd0);
      vcnt += int'(bus_e.out_valid);
      @(posedge clk); #1;
    end
    check("f1.valid_cycles", 32'(vcnt), 32'd5);
    check("f1.e.xor_stable", 32'(bus_e.out_xor), 32'h01);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("f1.e.out_valid_done", 32'(bus_e.out_valid), 32'd0);
    check("f1.e.in_ready_back",  32'(bus_e.in_ready),  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("f1.e.next_xor",   32'(bus_e.out_xor),   32'h55);
    check("f1.e.next_valid", 32'(bus_e.out_valid), 32'd1);
    idle_cycles(2);

    // exactly MAX_WORDS words: saturates the count, no overflow
    for (int i = 0; i < 4; i++) push(8'h0F, (i == 3));
    check("f4.e.out_xor",      32'(bus_e.out_xor),      32'h00);
    check("f4.e.out_count",    32'(bus_e.out_count),    32'd4);
    check("f4.e.out_overflow", 32'(bus_e.out_overflow), 32'd0);
    idle_cycles(2);

    // 6 x FF with MAX_WORDS=4: overflow
    for (int i = 0; i < 6; i++) push(8'hFF, (i == 5));
    check("ovf.e.out_xor",      32'(bus_e.out_xor),      32'h00);
    check("ovf.e.out_count",    32'(bus_e.out_count),    32'd4);
    check("ovf.e.out_overflow", 32'(bus_e.out_overflow), 32'd1);
    check("ovf.o.out_overflow", 32'(bus_o.out_overflow), 32'd1);
    idle_cycles(2);

    // reset after 2 of 4 words, then a fresh single-word frame
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid.e.busy",      32'(bus_e.busy),      32'd0);
    check("mid.e.out_valid", 32'(bus_e.out_valid), 32'd0);
    #2 rst_n = 1'b1;
    idle_cycles(1);
    exp_in = 8'h12;
    push(8'h12, 1'b1);
    check("mid.e.out_xor",      32'(bus_e.out_xor),      32'h12);
    check("mid.e.out_count",    32'(bus_e.out_count),    32'd1);
    check("mid.e.out_overflow", 32'(bus_e.out_overflow), 32'd0);
    check("mid.e.out_parity",   32'(bus_e.out_parity),   32'd0);
    check("mid.o.out_parity",   32'(bus_o.out_parity),   32'd1);
    check("mid.o.out_count",    32'(bus_o.out_count),    32'd1);
    idle_cycles(2);

    // reset while a result is held: discarded at once
    out_ready = 1'b0;
    push(8'h5A, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("hrst.e.out_valid", 32'(bus_e.out_valid), 32'd0);
    check("hrst.e.out_xor",   32'(bus_e.out_xor),   32'h00);
    check("hrst.e.in_ready",  32'(bus_e.in_ready),  32'd1);
    check("hrst.o.out_parity",32'(bus_o.out_parity),32'd1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    idle_cycles(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
